result_packer: RTL and testbench
================================

# result_packer

Downstream stage of the calculator controller: accepts 32-bit adder results one at a time and packs each consecutive pair into one 64-bit SRAM word, with the first result in the lower half and the second in the upper half. Completed words are held in a 2-entry output FIFO until the write side takes them via valid/ready. Per-half carry flags and a packed-word counter are carried alongside. The block replaces the controller's ad-hoc upper/lower buffer toggle with a proper handshaked staging point.

## Interface
Parameters:
- DATA_W, 32, width of one adder result (from calculator_pkg)
- MEM_WORD_SIZE, 64, SRAM word width; must equal 2*DATA_W
- CNT_W, 16, width of packed-word counter

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- clear_i  in  1  synchronous flush of staging, FIFO and counter
- res_valid_i  in  1  adder result valid
- res_data_i  in  DATA_W  adder sum
- res_carry_i  in  1  adder carry-out for this result
- res_ready_o  out  1  packer can accept a result this cycle
- flush_i  in  1  force-complete a half-filled word (upper half zero)
- half_sel_o  out  1  half the next accepted result fills (0 = lower, 1 = upper)
- word_valid_o  out  1  FIFO head holds a packed word
- word_data_o  out  MEM_WORD_SIZE  FIFO head word, {upper, lower}
- word_ovf_o  out  2  carry flags of head word, [1] = upper, [0] = lower
- word_ready_i  in  1  write side consumes head word this cycle
- words_packed_o  out  CNT_W  number of words pushed into FIFO since reset/clear

## Operation
- Result handshake: res_valid_i && res_ready_o at a rising edge.
- half_sel_o == 0 on handshake: res_data_i/res_carry_i go into the lower staging register; half_sel_o becomes 1.
- half_sel_o == 1 on handshake: {res_data_i, lower} with flags {res_carry_i, lower_carry} is pushed into the FIFO; half_sel_o becomes 0.
- res_ready_o = !rst_i && !(half_sel_o && fifo_count == 2). It depends on registered state only; there is no combinational path from word_ready_i.
- With half_sel_o == 0, results are always accepted, even when the FIFO is full.
- flush_i, half_sel_o == 1, FIFO not full, and no result handshake this cycle: push {0, lower} with flags {0, lower_carry}; half_sel_o becomes 0.
- flush_i has no effect when half_sel_o == 0, when the FIFO is full, or in a cycle with a result handshake. In the last case the result completes the word normally.
- FIFO: depth 2, registered storage, read/write pointers, count 0..2.
  - Pop when word_valid_o && word_ready_i.
  - Push and pop in the same cycle are allowed at count 0 or 1; the count is then unchanged (at count 0 only a push occurs).
  - word_data_o and word_ovf_o are 0 when the FIFO is empty.
- words_packed_o increments by 1 on every push, including flush pushes, and wraps modulo 2^CNT_W.
- clear_i: staging, half_sel_o, FIFO and counter return to reset values. Any handshake or flush in the same cycle is discarded. rst_i has priority over clear_i.

## Timing
- Reset values: half_sel_o=0, word_valid_o=0, word_data_o=0, word_ovf_o=0, words_packed_o=0, FIFO empty, staging=0. res_ready_o=0 while rst_i is high and 1 in the first cycle after.
- Latency: an upper-half handshake or effective flush at edge N gives word_valid_o=1 and valid word_data_o in cycle N+1.
- Throughput: one result per cycle sustained while word_ready_i is held high, i.e. one word per two cycles.
- word_valid_o and word_data_o are stable while word_valid_o && !word_ready_i.
- Reset or clear mid-word: a half-filled staged result is lost and never emitted.

## Test plan
- Reset, then results 0x00000001 and 0x00000002 on consecutive cycles with word_ready_i=1 -> word_data_o=0x00000002_00000001 one cycle after the second accept; words_packed_o=1; half_sel_o goes 0,1,0.
- Results 0xFFFFFFFF (carry=1) then 0x5 (carry=0) -> word_ovf_o=2'b01 alongside word 0x00000005_FFFFFFFF.
- word_ready_i=0, stream 6 results -> 2 words fill the FIFO; 5th result accepted into lower; res_ready_o=0 with half_sel_o=1; raising word_ready_i for one cycle -> res_ready_o=1 next cycle; order and data preserved.
- One result 0xABCD0123, then flush_i=1 -> word 0x00000000_ABCD0123 with word_ovf_o[1]=0; flush_i with half_sel_o=0 -> no push, counter unchanged.
- flush_i asserted in the same cycle as an upper-half result 0x7 -> single word {0x7, lower}; counter increments by 1 only.
- Two words queued plus one staged half, then clear_i=1 -> next cycle word_valid_o=0, half_sel_o=0, words_packed_o=0; a result accepted in the clear cycle does not appear.

Source files
------------

// File: rtl/result_packer.sv
// Pairs consecutive 32-bit adder results into 64-bit SRAM words {upper, lower}.
// Completed words wait in a 2-entry FIFO until the write side takes them.
//
// state  | meaning
// LOWER  | next accepted result fills the lower half
// UPPER  | lower half staged; next result (or flush) completes the word
module result_packer #(
    parameter int DATA_W        = 32,
    parameter int MEM_WORD_SIZE = 64,
    parameter int CNT_W         = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     res_valid_i,
    input  logic [DATA_W-1:0]        res_data_i,
    input  logic                     res_carry_i,
    output logic                     res_ready_o,
    input  logic                     flush_i,
    output logic                     half_sel_o,
    output logic                     word_valid_o,
    output logic [MEM_WORD_SIZE-1:0] word_data_o,
    output logic [1:0]               word_ovf_o,
    input  logic                     word_ready_i,
    output logic [CNT_W-1:0]         words_packed_o
);

    typedef enum logic {
        LOWER = 1'b0,
        UPPER = 1'b1
    } half_t;

    half_t                     half_q;
    logic [DATA_W-1:0]         lower_data_q;
    logic                      lower_carry_q;

    logic [MEM_WORD_SIZE-1:0]  mem_data_q [2];
    logic [1:0]                mem_ovf_q  [2];
    logic                      wr_ptr_q;
    logic                      rd_ptr_q;
    logic [1:0]                count_q;
    logic [CNT_W-1:0]          packed_cnt_q;

    logic                      fifo_full;
    logic                      res_hs;
    logic                      push_res;
    logic                      push_flush;
    logic                      push;
    logic                      pop;
    logic [MEM_WORD_SIZE-1:0]  push_data;
    logic [1:0]                push_ovf;

    assign fifo_full    = (count_q == 2'd2);
    assign word_valid_o = (count_q != 2'd0);
    assign half_sel_o   = (half_q == UPPER);

    // Only a completing (upper) result needs FIFO space; lower halves are always taken.
    assign res_ready_o  = !rst_i && !(half_q == UPPER && fifo_full);

    assign res_hs     = res_valid_i && res_ready_o;
    assign push_res   = res_hs && (half_q == UPPER);
    assign push_flush = flush_i && (half_q == UPPER) && !fifo_full && !res_hs;
    assign push       = push_res || push_flush;
    assign pop        = word_valid_o && word_ready_i;

    always_comb begin
        push_data = '0;
        push_ovf  = '0;
        if (push_res) begin
            push_data = {res_data_i, lower_data_q};
            push_ovf  = {res_carry_i, lower_carry_q};
        end else begin
            push_data = {{DATA_W{1'b0}}, lower_data_q};
            push_ovf  = {1'b0, lower_carry_q};
        end
    end

    assign word_data_o    = word_valid_o ? mem_data_q[rd_ptr_q] : '0;
    assign word_ovf_o     = word_valid_o ? mem_ovf_q[rd_ptr_q]  : 2'b00;
    assign words_packed_o = packed_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            half_q        <= LOWER;
            lower_data_q  <= '0;
            lower_carry_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data_q[i] <= '0;
                mem_ovf_q[i]  <= 2'b00;
            end
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            packed_cnt_q  <= '0;
        end else begin
            if (res_hs) begin
                if (half_q == LOWER) begin
                    lower_data_q  <= res_data_i;
                    lower_carry_q <= res_carry_i;
                    half_q        <= UPPER;
                end else begin
                    half_q        <= LOWER;
                end
            end else if (push_flush) begin
                half_q <= LOWER;
            end

            if (push) begin
                mem_data_q[wr_ptr_q] <= push_data;
                mem_ovf_q[wr_ptr_q]  <= push_ovf;
                wr_ptr_q             <= ~wr_ptr_q;
                packed_cnt_q         <= packed_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end

            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_result_packer.sv
// Directed self-checking bench for result_packer: pairing, carries, FIFO
// backpressure, flush, clear and sustained throughput.
module tb_result_packer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        res_valid_i;
    logic [31:0] res_data_i;
    logic        res_carry_i;
    logic        res_ready_o;
    logic        flush_i;
    logic        half_sel_o;
    logic        word_valid_o;
    logic [63:0] word_data_o;
    logic [1:0]  word_ovf_o;
    logic        word_ready_i;
    logic [15:0] words_packed_o;

    int checks = 0;
    int fails  = 0;

    result_packer #(.DATA_W(32), .MEM_WORD_SIZE(64), .CNT_W(16)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .res_valid_i    (res_valid_i),
        .res_data_i     (res_data_i),
        .res_carry_i    (res_carry_i),
        .res_ready_o    (res_ready_o),
        .flush_i        (flush_i),
        .half_sel_o     (half_sel_o),
        .word_valid_o   (word_valid_o),
        .word_data_o    (word_data_o),
        .word_ovf_o     (word_ovf_o),
        .word_ready_i   (word_ready_i),
        .words_packed_o (words_packed_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; clear_i = 1'b0; res_valid_i = 1'b0; res_data_i = '0;
        res_carry_i = 1'b0; flush_i = 1'b0; word_ready_i = 1'b0;
        step(); step();
        checks++;
        if (res_ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", res_ready_o); end
        checks++;
        if (word_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", word_valid_o); end
        checks++;
        if (half_sel_o !== 1'b0) begin fails++; $display("FAIL reset_half: got %b expected 0", half_sel_o); end
        checks++;
        if (word_data_o !== 64'h0 || word_ovf_o !== 2'b00) begin
            fails++; $display("FAIL reset_data: got %h/%b expected 0/00", word_data_o, word_ovf_o);
        end
        checks++;
        if (words_packed_o !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", words_packed_o); end
        rst_i = 1'b0;
        #1;
        checks++;
        if (res_ready_o !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b expected 1", res_ready_o); end
    endtask

    task automatic test_pair();
        word_ready_i = 1'b1;
        res_valid_i = 1'b1; res_data_i = 32'h0000_0001; res_carry_i = 1'b0;
        step();
        checks++;
        if (half_sel_o !== 1'b1) begin fails++; $display("FAIL pair_half1: got %b expected 1", half_sel_o); end
        res_data_i = 32'h0000_0002;
        step();
        res_valid_i = 1'b0;
        checks++;
        if (half_sel_o !== 1'b0) begin fails++; $display("FAIL pair_half0: got %b expected 0", half_sel_o); end
        checks++;
        if (word_valid_o !== 1'b1 || word_data_o !== 64'h00000002_00000001) begin
            fails++; $display("FAIL pair_word: got v=%b %h expected v=1 0000000200000001", word_valid_o, word_data_o);
        end
        checks++;
        if (words_packed_o !== 16'd1) begin fails++; $display("FAIL pair_count: got %0d expected 1", words_packed_o); end
        step();
        checks++;
        if (word_valid_o !== 1'b0) begin fails++; $display("FAIL pair_popped: got %b expected 0", word_valid_o); end
    endtask

    task automatic test_carry();
        res_valid_i = 1'b1; res_data_i = 32'hFFFF_FFFF; res_carry_i = 1'b1;
        step();
        res_data_i = 32'h0000_0005; res_carry_i = 1'b0;
        step();
        res_valid_i = 1'b0;
        checks++;
        if (word_data_o !== 64'h00000005_FFFFFFFF || word_ovf_o !== 2'b01) begin
            fails++; $display("FAIL carry_word: got %h ovf=%b expected 00000005ffffffff ovf=01", word_data_o, word_ovf_o);
        end
        checks++;
        if (words_packed_o !== 16'd2) begin fails++; $display("FAIL carry_count: got %0d expected 2", words_packed_o); end
        step();
    endtask

    task automatic test_fifo_full();
        word_ready_i = 1'b0;
        res_valid_i  = 1'b1; res_carry_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            res_data_i = 32'h10 + i;
            step();
        end
        checks++;
        if (word_data_o !== 64'h00000011_00000010 || half_sel_o !== 1'b0 || res_ready_o !== 1'b1) begin
            fails++; $display("FAIL full_lower_ready: got %h half=%b rdy=%b expected 0000001100000010 half=0 rdy=1",
                              word_data_o, half_sel_o, res_ready_o);
        end
        res_data_i = 32'h14;
        step();
        checks++;
        if (half_sel_o !== 1'b1 || res_ready_o !== 1'b0) begin
            fails++; $display("FAIL full_block: got half=%b rdy=%b expected half=1 rdy=0", half_sel_o, res_ready_o);
        end
        res_data_i = 32'h15;
        step();
        checks++;
        if (half_sel_o !== 1'b1 || word_data_o !== 64'h00000011_00000010 || words_packed_o !== 16'd4) begin
            fails++; $display("FAIL full_stall: got half=%b %h cnt=%0d expected half=1 0000001100000010 cnt=4",
                              half_sel_o, word_data_o, words_packed_o);
        end
        word_ready_i = 1'b1;
        step();
        word_ready_i = 1'b0;
        checks++;
        if (res_ready_o !== 1'b1 || word_data_o !== 64'h00000013_00000012) begin
            fails++; $display("FAIL full_release: got rdy=%b %h expected rdy=1 0000001300000012", res_ready_o, word_data_o);
        end
        step();
        res_valid_i = 1'b0;
        checks++;
        if (half_sel_o !== 1'b0 || words_packed_o !== 16'd5 || res_ready_o !== 1'b1) begin
            fails++; $display("FAIL full_refill: got half=%b cnt=%0d rdy=%b expected half=0 cnt=5 rdy=1",
                              half_sel_o, words_packed_o, res_ready_o);
        end
        word_ready_i = 1'b1;
        step();
        checks++;
        if (word_valid_o !== 1'b1 || word_data_o !== 64'h00000015_00000014) begin
            fails++; $display("FAIL full_order: got v=%b %h expected v=1 0000001500000014", word_valid_o, word_data_o);
        end
        step();
        checks++;
        if (word_valid_o !== 1'b0) begin fails++; $display("FAIL full_drain: got %b expected 0", word_valid_o); end
    endtask

    task automatic test_flush();
        res_valid_i = 1'b1; res_data_i = 32'hABCD_0123; res_carry_i = 1'b1;
        step();
        res_valid_i = 1'b0; res_carry_i = 1'b0; flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checks++;
        if (word_valid_o !== 1'b1 || word_data_o !== 64'h00000000_ABCD0123 || word_ovf_o !== 2'b01) begin
            fails++; $display("FAIL flush_word: got v=%b %h ovf=%b expected v=1 00000000abcd0123 ovf=01",
                              word_valid_o, word_data_o, word_ovf_o);
        end
        checks++;
        if (words_packed_o !== 16'd6 || half_sel_o !== 1'b0) begin
            fails++; $display("FAIL flush_count: got cnt=%0d half=%b expected cnt=6 half=0", words_packed_o, half_sel_o);
        end
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checks++;
        if (word_valid_o !== 1'b0 || words_packed_o !== 16'd6) begin
            fails++; $display("FAIL flush_idle: got v=%b cnt=%0d expected v=0 cnt=6", word_valid_o, words_packed_o);
        end
    endtask

    task automatic test_flush_with_result();
        res_valid_i = 1'b1; res_data_i = 32'h9; res_carry_i = 1'b0;
        step();
        res_data_i = 32'h7; res_carry_i = 1'b1; flush_i = 1'b1;
        step();
        res_valid_i = 1'b0; res_carry_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (word_data_o !== 64'h00000007_00000009 || word_ovf_o !== 2'b10) begin
            fails++; $display("FAIL flush_res_word: got %h ovf=%b expected 0000000700000009 ovf=10", word_data_o, word_ovf_o);
        end
        step();
        checks++;
        if (words_packed_o !== 16'd7 || word_valid_o !== 1'b0) begin
            fails++; $display("FAIL flush_res_count: got cnt=%0d v=%b expected cnt=7 v=0", words_packed_o, word_valid_o);
        end
    endtask

    task automatic test_clear();
        word_ready_i = 1'b0;
        res_valid_i  = 1'b1; res_carry_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            res_data_i = 32'h20 + i;
            step();
        end
        res_data_i = 32'h25; clear_i = 1'b1;
        step();
        clear_i = 1'b0; res_valid_i = 1'b0;
        checks++;
        if (word_valid_o !== 1'b0 || half_sel_o !== 1'b0 || words_packed_o !== 16'd0 || word_data_o !== 64'h0) begin
            fails++; $display("FAIL clear_state: got v=%b half=%b cnt=%0d %h expected v=0 half=0 cnt=0 0",
                              word_valid_o, half_sel_o, words_packed_o, word_data_o);
        end
        res_valid_i = 1'b1; res_carry_i = 1'b0; res_data_i = 32'h30; clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        checks++;
        if (half_sel_o !== 1'b0) begin fails++; $display("FAIL clear_discard: got half=%b expected 0", half_sel_o); end
        res_data_i = 32'h31;
        step();
        res_data_i = 32'h32;
        step();
        res_valid_i = 1'b0;
        checks++;
        if (word_data_o !== 64'h00000032_00000031 || word_ovf_o !== 2'b00 || words_packed_o !== 16'd1) begin
            fails++; $display("FAIL clear_after: got %h ovf=%b cnt=%0d expected 0000003200000031 ovf=00 cnt=1",
                              word_data_o, word_ovf_o, words_packed_o);
        end
        word_ready_i = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_word;
        word_ready_i = 1'b1;
        res_valid_i  = 1'b1; res_carry_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            res_data_i = 32'h40 + i;
            step();
            checks++;
            if (res_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, res_ready_o); end
            if (i % 2 == 1) begin
                exp_word = {32'h40 + i, 32'h40 + i - 1};
                checks++;
                if (word_valid_o !== 1'b1 || word_data_o !== exp_word) begin
                    fails++; $display("FAIL b2b_word[%0d]: got v=%b %h expected v=1 %h", i, word_valid_o, word_data_o, exp_word);
                end
            end
        end
        res_valid_i = 1'b0;
        checks++;
        if (words_packed_o !== 16'd4) begin fails++; $display("FAIL b2b_count: got %0d expected 4", words_packed_o); end
        step();
        checks++;
        if (word_valid_o !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b expected 0", word_valid_o); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_carry();
        test_fifo_full();
        test_flush();
        test_flush_with_result();
        test_clear();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
